alu_result_history: RTL and testbench

ALU_RESULT_HISTORY -- requirements
Module: alu_result_history

---
 rtl/alu_pkg.sv | 24 ++
 rtl/hex_decoder.sv | 31 +++
 rtl/alu_result_history.sv | 121 ++++++++++++
 tb/tb_alu_result_history.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU result history display block.
package alu_pkg;

  // Default number of stored results; must be a power of two.
  localparam int unsigned ALU_DEPTH = 8;

  // Width of the count output; holds 0..ALU_DEPTH inclusive.
  localparam int unsigned ALU_COUNT_W = 4;

  // Active-low seven-segment pattern with every segment off.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Pointer width for a given depth. At least one bit so that DEPTH = 1
  // still produces a legal vector.
  function automatic int unsigned ptr_width(input int unsigned depth);
    int unsigned w;
    w = $clog2(depth);
    return (w == 0) ? 1 : w;
  endfunction

  // Pointer width for the default depth.
  localparam int unsigned ALU_PTR_W = ptr_width(ALU_DEPTH);

endpackage

// File: rtl/hex_decoder.sv
// Hex digit to active-low seven-segment pattern, bit 0 = segment a.
module hex_decoder (
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  // Look up the segment pattern for one hex digit.
  always_comb begin
    o_seg = '1;
    unique case (i_digit)
      4'h0: o_seg = ~7'h3F;
      4'h1: o_seg = ~7'h06;
      4'h2: o_seg = ~7'h5B;
      4'h3: o_seg = ~7'h4F;
      4'h4: o_seg = ~7'h66;
      4'h5: o_seg = ~7'h6D;
      4'h6: o_seg = ~7'h7D;
      4'h7: o_seg = ~7'h07;
      4'h8: o_seg = ~7'h7F;
      4'h9: o_seg = ~7'h6F;
      4'hA: o_seg = ~7'h77;
      4'hB: o_seg = ~7'h7C;
      4'hC: o_seg = ~7'h39;
      4'hD: o_seg = ~7'h5E;
      4'hE: o_seg = ~7'h79;
      4'hF: o_seg = ~7'h71;
      default: o_seg = '1;
    endcase
  end

endmodule

// File: rtl/alu_result_history.sv
// Circular history of ALU accumulator results with a pushbutton-scrolled
// seven-segment view. View offset 0 is always the newest entry.
module alu_result_history
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = ALU_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   result_valid,
  input  logic [7:0]             result,
  input  logic                   scroll_n,
  output logic [6:0]             hex_lo,
  output logic [6:0]             hex_hi,
  output logic [6:0]             hex_idx,
  output logic [ALU_COUNT_W-1:0] count,
  output logic                   full,
  output logic                   overflow
);

  localparam int unsigned          PTR_W   = ptr_width(DEPTH);
  localparam logic [ALU_COUNT_W-1:0] DEPTH_C = ALU_COUNT_W'(DEPTH);

  logic [7:0]             r_mem [DEPTH];
  logic [PTR_W-1:0]       r_wp;
  logic [PTR_W-1:0]       r_view;
  logic [ALU_COUNT_W-1:0] r_count;
  logic                   r_overflow;
  logic                   r_sync1;
  logic                   r_sync2;
  logic                   r_edge;

  logic                   w_press;
  logic                   w_full;
  logic                   w_empty;
  logic [ALU_COUNT_W-1:0] w_view_inc;
  logic [PTR_W-1:0]       w_rd_addr;
  logic [7:0]             w_sel;
  logic [6:0]             w_seg_lo;
  logic [6:0]             w_seg_hi;
  logic [6:0]             w_seg_idx;

  // Two-flop synchronizer plus previous-level flop for falling-edge detect.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_edge  <= 1'b1;
    end else begin
      r_sync1 <= scroll_n;
      r_sync2 <= r_sync1;
      r_edge  <= r_sync2;
    end
  end

  // One pulse per press: synchronized level was high, is now low.
  assign w_press    = r_edge & ~r_sync2;
  assign w_full     = (r_count == DEPTH_C);
  assign w_empty    = (r_count == '0);
  assign w_view_inc = ALU_COUNT_W'(r_view) + ALU_COUNT_W'(1);

  // Result storage; deliberately not reset, entries are only read once written.
  always_ff @(posedge clock) begin
    if (result_valid && !reset) begin
      r_mem[r_wp] <= result;
    end
  end

  // Pointer, fill count, sticky overflow and view offset. A write always
  // snaps the view back to the newest entry, even when a press coincides.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wp       <= '0;
      r_count    <= '0;
      r_view     <= '0;
      r_overflow <= 1'b0;
    end else if (result_valid) begin
      r_wp   <= r_wp + PTR_W'(1);
      r_view <= '0;
      if (w_full) begin
        r_overflow <= 1'b1;
      end else begin
        r_count <= r_count + ALU_COUNT_W'(1);
      end
    end else if (w_press) begin
      if (w_view_inc < r_count) begin
        r_view <= r_view + PTR_W'(1);
      end else begin
        r_view <= '0;
      end
    end
  end

  // Newest entry sits just below the write pointer; modular arithmetic
  // handles the wrap across address 0.
  assign w_rd_addr = r_wp - PTR_W'(1) - r_view;
  assign w_sel     = r_mem[w_rd_addr];

  hex_decoder u_dec_lo (
    .i_digit (w_sel[3:0]),
    .o_seg   (w_seg_lo)
  );

  hex_decoder u_dec_hi (
    .i_digit (w_sel[7:4]),
    .o_seg   (w_seg_hi)
  );

  hex_decoder u_dec_idx (
    .i_digit (4'(r_view)),
    .o_seg   (w_seg_idx)
  );

  assign hex_lo   = w_empty ? SEG_BLANK : w_seg_lo;
  assign hex_hi   = w_empty ? SEG_BLANK : w_seg_hi;
  assign hex_idx  = w_empty ? SEG_BLANK : w_seg_idx;
  assign count    = r_count;
  assign full     = w_full;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_alu_result_history.sv
// Directed scoreboard bench for alu_result_history.
module tb_alu_result_history;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       result_valid = 1'b0;
  logic [7:0] result = '0;
  logic       scroll_n = 1'b1;
  logic [6:0] hex_lo, hex_hi, hex_idx;
  logic [3:0] count;
  logic       full, overflow;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    string      name;
    logic [6:0] lo, hi, idx;
    logic [3:0] cnt;
    logic       full, ovf;
  } exp_t;

  exp_t exp_q[$];

  alu_result_history #(.DEPTH(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .result_valid (result_valid),
    .result       (result),
    .scroll_n     (scroll_n),
    .hex_lo       (hex_lo),
    .hex_hi       (hex_hi),
    .hex_idx      (hex_idx),
    .count        (count),
    .full         (full),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  // Hand-written active-low patterns, bit 0 = segment a.
  function automatic logic [6:0] seg(input int unsigned d);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[d % 16];
  endfunction

  task automatic exp_show(input string name, input int unsigned val,
                          input int unsigned idx, input int unsigned cnt,
                          input logic f, input logic o);
    exp_t e;
    e.name = name;
    e.lo   = seg(val % 16);
    e.hi   = seg((val / 16) % 16);
    e.idx  = seg(idx);
    e.cnt  = 4'(cnt);
    e.full = f;
    e.ovf  = o;
    exp_q.push_back(e);
  endtask

  task automatic exp_blank(input string name);
    exp_t e;
    e.name = name;
    e.lo   = 7'h7F;
    e.hi   = 7'h7F;
    e.idx  = 7'h7F;
    e.cnt  = 4'd0;
    e.full = 1'b0;
    e.ovf  = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input string field,
                     input logic [6:0] act, input logic [6:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s.%s: actual=%h required=%h", name, field, act, req);
    end
  endtask

  // Monitor: compare every queued expectation on the falling edge.
  always @(negedge clock) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "hex_lo",   hex_lo,         e.lo);
      chk(e.name, "hex_hi",   hex_hi,         e.hi);
      chk(e.name, "hex_idx",  hex_idx,        e.idx);
      chk(e.name, "count",    {3'b0, count},  {3'b0, e.cnt});
      chk(e.name, "full",     {6'b0, full},   {6'b0, e.full});
      chk(e.name, "overflow", {6'b0, overflow}, {6'b0, e.ovf});
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] v);
    @(negedge clock);
    result       = v;
    result_valid = 1'b1;
    @(posedge clock);
    #1 result_valid = 1'b0;
  endtask

  task automatic do_press();
    @(negedge clock);
    scroll_n = 1'b0;
    repeat (5) @(posedge clock);
    #1 scroll_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;
  endtask

  initial begin
    do_reset();
    repeat (2) @(posedge clock);
    #1 exp_blank("reset_idle");

    // Two writes, then scroll through both and wrap.
    do_write(8'h3C);
    do_write(8'hA5);
    exp_show("two_writes", 'hA5, 0, 2, 1'b0, 1'b0);
    do_press();
    exp_show("press1", 'h3C, 1, 2, 1'b0, 1'b0);
    do_press();
    exp_show("press2_wrap", 'hA5, 0, 2, 1'b0, 1'b0);

    // Nine writes overflow an 8-deep buffer.
    do_reset();
    for (int i = 1; i <= 9; i++) do_write(8'(i));
    exp_show("overflow_v0", 'h09, 0, 8, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) do_press();
    exp_show("oldest_v7", 'h02, 7, 8, 1'b1, 1'b1);
    do_press();
    exp_show("wrap_v0", 'h09, 0, 8, 1'b1, 1'b1);

    // Long hold: single increment on the third edge after the fall.
    @(negedge clock);
    scroll_n = 1'b0;
    @(posedge clock); #1 exp_show("hold_e1", 'h09, 0, 8, 1'b1, 1'b1);
    @(posedge clock); #1 exp_show("hold_e2", 'h09, 0, 8, 1'b1, 1'b1);
    @(posedge clock); #1 exp_show("hold_e3", 'h08, 1, 8, 1'b1, 1'b1);
    repeat (17) @(posedge clock);
    #1 exp_show("hold_end", 'h08, 1, 8, 1'b1, 1'b1);
    scroll_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    do_press();
    do_press();
    exp_show("view3", 'h06, 3, 8, 1'b1, 1'b1);

    // Press pulse and write in the same cycle: write wins.
    @(negedge clock);
    scroll_n = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    result       = 8'h7E;
    result_valid = 1'b1;
    @(posedge clock);
    #1 result_valid = 1'b0;
    exp_show("coincide", 'h7E, 0, 8, 1'b1, 1'b1);
    repeat (2) @(posedge clock);
    #1 exp_show("coincide_hold", 'h7E, 0, 8, 1'b1, 1'b1);
    scroll_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;

    // Reset coinciding with a write.
    do_reset();
    for (int i = 0; i < 5; i++) do_write(8'(8'h11 + i));
    exp_show("five_writes", 'h15, 0, 5, 1'b0, 1'b0);
    @(negedge clock);
    reset        = 1'b1;
    result_valid = 1'b1;
    result       = 8'hEE;
    @(posedge clock);
    #1 reset = 1'b0;
    result_valid = 1'b0;
    exp_blank("reset_vs_write");
    @(posedge clock);
    #1 exp_blank("reset_vs_write_hold");
    do_write(8'h42);
    exp_show("post_reset_write", 'h42, 0, 1, 1'b0, 1'b0);
    do_press();
    exp_show("single_entry_press", 'h42, 0, 1, 1'b0, 1'b0);
    do_write(8'h43);
    do_press();
    exp_show("second_entry_press", 'h42, 1, 2, 1'b0, 1'b0);

    repeat (3) @(posedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
